bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per operand (legal range 1..16).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have the port a, input, 4*DIGITS bits: augend/minuend, digit 0 in bits [3:0].
REQ-006 The block SHALL have the port b, input, 4*DIGITS bits: addend/subtrahend, same packing as a.
REQ-007 The block SHALL have the port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b.
REQ-008 The block SHALL have the port cin, input, 1 bit: decimal carry-in, used only when sub=0.
REQ-009 The block SHALL have the port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse when sum and cout become valid.
REQ-011 The block SHALL have the port sum, output, 4*DIGITS bits: BCD result, held until the next accepted start.
REQ-012 The block SHALL have the port cout, output, 1 bit: decimal carry out (for sub=1, 1 = no borrow).
REQ-013 The block SHALL have the port err, output, 1 bit: invalid-digit flag (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b, sub and cin, load digit index 0, load carry = (sub ? 1 : cin), and go to RUN.
REQ-016 In RUN, the block SHALL process one digit per cycle: digit sum = a_i + b'_i + carry, where b'_i = (sub ? 9 - b_i : b_i).
REQ-017 For each digit, if the binary digit sum exceeds 9, the block SHALL add 6, write the low 4 bits to sum digit i and set the next carry to 1; otherwise it SHALL write the digit sum unchanged and set the next carry to 0.
REQ-018 After digit DIGITS-1 is processed, the block SHALL set cout = final carry and go to DONE.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-020 Latency SHALL be fixed: with start accepted at edge k, done is high in the cycle after edge k+DIGITS+1, and busy is high for exactly DIGITS cycles.
REQ-021 A start asserted during RUN or DONE SHALL be ignored, with no queuing.
REQ-022 A start asserted in the same cycle that done is high SHALL be ignored; start is accepted only from IDLE.
REQ-023 sum, cout and err SHALL stay stable from done until the next accepted start.
REQ-024 For sub=1 with a<b, the result SHALL be the tens-complement (a + 10^DIGITS - b) with cout=0; no sign conversion is performed.
REQ-025 Operand changes after start is accepted SHALL have no effect on the result.

Reset
REQ-026 Asserting rst at any time, including mid-RUN, SHALL force IDLE and clear sum, cout, err, busy, done and the digit index to 0 without waiting for a clock edge.
REQ-027 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro BCD_INVALID_DIGIT_CHECK_EN defined, the block SHALL set err = 1 with done if any latched digit of a or b exceeds 9; the sum is still produced per REQ-016/017.
REQ-029 With macro BCD_INVALID_DIGIT_CHECK_EN undefined, err SHALL be tied to 0 and no check logic is generated.

Structure
REQ-030 The FSM state enum, the constant BCD_MAX_DIGIT (9) and the constant BCD_ADJUST (6) SHALL live in shared package bcd_pkg.
REQ-031 The single-digit combinational add-and-correct SHALL be a sub-module bcd_digit_add (inputs: 4-bit x, 4-bit y, carry-in; outputs: 4-bit s, carry-out), instantiated once and reused every cycle.

Verification (DIGITS=4)
REQ-032 Test: a=1234, b=8766, sub=0, cin=0 -> sum=0000, cout=1, done 6 cycles after start edge.
REQ-033 Test: a=9999, b=0000, sub=0, cin=1 -> sum=0000, cout=1.
REQ-034 Test: a=5000, b=1234, sub=1 -> sum=3766, cout=1; a=1234, b=5000, sub=1 -> sum=6234, cout=0.
REQ-035 Test: start pulsed again on the second RUN cycle and again on the done cycle -> only one done, result unchanged.
REQ-036 Test: rst asserted on the third RUN cycle -> busy=0, sum=0 immediately; a following start of 0001+0001 -> sum=0002.
REQ-037 Test, with macro defined: a=12A4 (hex), b=0001 -> err=1 with done; with macro undefined -> err=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Holds the control FSM state encoding and the decimal digit limits.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] BCD_ADJUST    = 4'd6;

    // A nibble is a legal BCD digit only in the range 0..9.
    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal correction.
// The binary sum of two digits and a carry is folded back into 0..9 plus carry.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] raw;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        s   = 4'd0;
        co  = 1'b0;
        raw = {1'b0, x} + {1'b0, y} + {4'd0, ci};
        if (raw > {1'b0, BCD_MAX_DIGIT}) begin
            // Adding 6 skips the six unused codes A..F; the wrap past 15 is the decimal carry.
            s  = raw[3:0] + BCD_ADJUST;
            co = 1'b1;
        end else begin
            s  = raw[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock through a shared digit adder.
// Optional invalid-digit flag enabled by defining BCD_INVALID_DIGIT_CHECK_EN.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_t          state;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                sub_q;
    logic                carry;

    logic [3:0]          x_digit;
    logic [3:0]          b_digit;
    logic [3:0]          y_digit;
    logic [3:0]          s_digit;
    logic                c_next;

    // Select the current digit pair; subtraction uses the nines complement of b.
    always_comb begin
        x_digit = 4'd0;
        b_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                x_digit = a_q[4*i +: 4];
                b_digit = b_q[4*i +: 4];
            end
        end
        y_digit = sub_q ? (BCD_MAX_DIGIT - b_digit) : b_digit;
    end

    bcd_digit_add u_digit_add (
        .x  (x_digit),
        .y  (y_digit),
        .ci (carry),
        .s  (s_digit),
        .co (c_next)
    );

`ifdef BCD_INVALID_DIGIT_CHECK_EN
    logic any_invalid;
    logic err_q;

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_invalid = any_invalid | digit_invalid(a_q[4*i +: 4])
                                      | digit_invalid(b_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start && !done) begin
            err_q <= 1'b0;
        end else if (state == DONE) begin
            err_q <= any_invalid;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The done cycle is spent in IDLE, so a start coinciding with done is refused here.
                    if (start && !done) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[4*i +: 4] <= s_digit;
                        end
                    end
                    carry <= c_next;
                    if (idx == LAST_IDX) begin
                        cout  <= c_next;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4) with directed decimal vectors.
// Expected err follows BCD_INVALID_DIGIT_CHECK_EN.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int PERIOD = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sub_in;
    logic        cin_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        time         t_issue;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt = 0;

`ifdef BCD_INVALID_DIGIT_CHECK_EN
    localparam logic ERR_ON_BAD = 1'b1;
`else
    localparam logic ERR_ON_BAD = 1'b0;
`endif

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .sub   (sub_in),
        .cin   (cin_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks result, latency and busy width.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: sum %0h with no pending operation at %0t", sum, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("err", 32'(err), 32'(e.err));
                    check("latency", 32'(($time - e.t_issue) / PERIOD), 32'(DIGITS + 2));
                    check("busy_cycles", 32'(busy_cnt), 32'(DIGITS));
                end
                busy_cnt = 0;
            end
        end
    end

    // Drives one start pulse, then scrambles operands to show they were latched.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv,
                         input logic [15:0] esum, input logic ecout, input logic eerr, input logic push);
        @(negedge clk);
        a_in   = av;
        b_in   = bv;
        sub_in = sv;
        cin_in = cv;
        start  = 1'b1;
        if (push) exp_q.push_back('{sum: esum, cout: ecout, err: eerr, t_issue: $time});
        @(negedge clk);
        start  = 1'b0;
        a_in   = 16'hFFFF;
        b_in   = 16'hFFFF;
        sub_in = ~sv;
        cin_in = ~cv;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        sub_in = 1'b0;
        cin_in = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_drain("add_1234_8766");
        issue(16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_drain("add_9999_cin");
        issue(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0, 1'b1);
        wait_drain("sub_5000_1234");
        issue(16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0, 1'b1);
        wait_drain("sub_1234_5000");
        issue(16'h0456, 16'h0789, 1'b0, 1'b0, 16'h1245, 1'b0, 1'b0, 1'b1);
        wait_drain("add_0456_0789");
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_drain("sub_zero");
        issue(16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b1);
        wait_drain("sub_cin_ignored");

        // Extra starts on the second RUN cycle and on the done cycle must be dropped.
        issue(16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_in  = 16'h0001;
        b_in  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen_for_retrigger", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (DIGITS + 4) begin
            @(negedge clk);
            check("idle_after_ignored_start", 32'(busy), 32'd0);
        end
        check("retrigger_queue_empty", 32'(exp_q.size()), 32'd0);
        check("retrigger_sum_held", 32'(sum), 32'h5000);

        // Reset on the third RUN cycle clears outputs without a clock edge.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        wait_drain("after_rst");

        issue(16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, ERR_ON_BAD, 1'b1);
        wait_drain("invalid_digit");
        issue(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
        wait_drain("err_clears");

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
